// File: rtl/ariane_pkg.sv
// rtl/ariane_pkg.sv - shared constants and types for the perf sampling slice
package ariane_pkg;

   // Native register width of the core
   localparam int unsigned XLEN = 64;

   // Performance counter CSR addresses used by the sampler
   localparam logic [11:0] CSR_MHPM_COUNTER_3  = 12'hB03;
   localparam logic [11:0] CSR_MHPM_COUNTER_3H = 12'hB83;

   // Index reported on the timestamp header beat
   localparam logic [2:0] PERF_SAMPLE_HDR_IDX = 3'd7;

   // Sampling engine states; HDR is reached only with timestamps, RD_HI only on 32-bit cores
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      HDR   = 3'd1,
      RD_LO = 3'd2,
      RD_HI = 3'd3,
      PUSH  = 3'd4
   } perf_sample_state_e;

endpackage

// File: rtl/perf_sample_timer.sv
// rtl/perf_sample_timer.sv - period down-counter producing one-cycle sampling ticks
module perf_sample_timer import ariane_pkg::*; #(
   parameter int unsigned PeriodWidth = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   en_i,
   input  logic                   debug_i,
   input  logic [PeriodWidth-1:0] period_i,
   output logic                   tick_o
);

   logic [PeriodWidth-1:0] timer_d, timer_q;
   logic                   tick_d, tick_q;

   // Preload while disabled so the first tick lands exactly one period after enable;
   // debug freezes the count, and a zero count simply reloads without ticking.
   always_comb begin
      timer_d = timer_q;
      tick_d  = 1'b0;
      if (!en_i || (period_i == '0)) begin
         timer_d = period_i;
      end else if (debug_i) begin
         timer_d = timer_q;
      end else if (timer_q == '0) begin
         timer_d = period_i;
      end else if (timer_q == PeriodWidth'(1)) begin
         timer_d = period_i;
         tick_d  = 1'b1;
      end else begin
         timer_d = timer_q - PeriodWidth'(1);
      end
   end

   // Timer and registered tick
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         timer_q <= '0;
         tick_q  <= 1'b0;
      end else begin
         timer_q <= timer_d;
         tick_q  <= tick_d;
      end
   end

   assign tick_o = tick_q;

endmodule

// File: rtl/perf_sample_ctrl.sv
// rtl/perf_sample_ctrl.sv - counter-port arbiter and periodic sampler (PERF_SAMPLE_TIMESTAMP_EN adds header beat)
module perf_sample_ctrl import ariane_pkg::*; #(
   parameter int unsigned NumCounters = 6,
   parameter int unsigned PeriodWidth = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   debug_mode_i,
   input  logic                   csr_req_i,
   input  logic [11:0]            csr_addr_i,
   input  logic                   csr_we_i,
   input  logic [XLEN-1:0]        csr_wdata_i,
   output logic [XLEN-1:0]        csr_rdata_o,
   output logic [11:0]            pc_addr_o,
   output logic                   pc_we_o,
   output logic [XLEN-1:0]        pc_wdata_o,
   input  logic [XLEN-1:0]        pc_rdata_i,
   input  logic                   cfg_en_i,
   input  logic [PeriodWidth-1:0] cfg_period_i,
   output logic                   smp_valid_o,
   input  logic                   smp_ready_i,
   output logic [2:0]             smp_idx_o,
   output logic [63:0]            smp_data_o,
   output logic                   smp_last_o,
   output logic                   busy_o,
   output logic                   drop_o
);

   localparam logic [2:0] LastIdx = 3'(NumCounters - 1);

   perf_sample_state_e state_d, state_q;
   logic [2:0]         k_d, k_q;
   logic [63:0]        data_d, data_q;
   logic               drop_d, drop_q;
   logic [11:0]        smp_addr;
   logic               tick;

   perf_sample_timer #(
      .PeriodWidth (PeriodWidth)
   ) i_timer (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .en_i     (cfg_en_i),
      .debug_i  (debug_mode_i),
      .period_i (cfg_period_i),
      .tick_o   (tick)
   );

`ifdef PERF_SAMPLE_TIMESTAMP_EN
   logic [63:0] ts_cnt_d, ts_cnt_q;
   logic [63:0] ts_d, ts_q;

   // Free-running cycle count, latched when a tick starts a burst
   always_comb begin
      ts_cnt_d = ts_cnt_q + 64'd1;
      ts_d     = ts_q;
      if ((state_q == IDLE) && tick) begin
         ts_d = ts_cnt_q;
      end
   end

   // Timestamp registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ts_cnt_q <= '0;
         ts_q     <= '0;
      end else begin
         ts_cnt_q <= ts_cnt_d;
         ts_q     <= ts_d;
      end
   end
`endif

   // Sampler FSM: reads yield to the CSR file, beats hold until accepted
   always_comb begin
      state_d  = state_q;
      k_d      = k_q;
      data_d   = data_q;
      smp_addr = 12'h000;
      unique case (state_q)
         IDLE: begin
            if (tick) begin
               k_d = 3'd0;
`ifdef PERF_SAMPLE_TIMESTAMP_EN
               state_d = HDR;
`else
               state_d = RD_LO;
`endif
            end
         end
`ifdef PERF_SAMPLE_TIMESTAMP_EN
         HDR: begin
            if (smp_ready_i) begin
               state_d = RD_LO;
            end
         end
`endif
         RD_LO: begin
            smp_addr = CSR_MHPM_COUNTER_3 + 12'(k_q);
            if (!csr_req_i) begin
               data_d[XLEN-1:0] = pc_rdata_i;
               state_d          = (XLEN == 32) ? RD_HI : PUSH;
            end
         end
         RD_HI: begin
            smp_addr = CSR_MHPM_COUNTER_3H + 12'(k_q);
            if (!csr_req_i) begin
               data_d[63:32] = pc_rdata_i[31:0];
               state_d       = PUSH;
            end
         end
         PUSH: begin
            if (smp_ready_i) begin
               if (k_q == LastIdx) begin
                  state_d = IDLE;
               end else begin
                  k_d     = k_q + 3'd1;
                  state_d = RD_LO;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // A tick that arrives while a burst is still running is reported, not queued
   always_comb begin
      drop_d = tick && (state_q != IDLE);
   end

   // FSM, index, capture and drop registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         k_q     <= 3'd0;
         data_q  <= '0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         data_q  <= data_d;
         drop_q  <= drop_d;
      end
   end

   // Port mux: the CSR file always wins; the sampler only ever reads
   always_comb begin
      pc_addr_o   = csr_req_i ? csr_addr_i : smp_addr;
      pc_we_o     = csr_req_i & csr_we_i;
      pc_wdata_o  = csr_req_i ? csr_wdata_i : '0;
      csr_rdata_o = csr_req_i ? pc_rdata_i : '0;
   end

   // Stream outputs come straight from state so they stay stable under backpressure
   always_comb begin
      smp_valid_o = (state_q == PUSH);
      smp_idx_o   = k_q;
      smp_data_o  = data_q;
`ifdef PERF_SAMPLE_TIMESTAMP_EN
      if (state_q == HDR) begin
         smp_valid_o = 1'b1;
         smp_idx_o   = PERF_SAMPLE_HDR_IDX;
         smp_data_o  = ts_q;
      end
`endif
      smp_last_o = (state_q == PUSH) && (k_q == LastIdx);
      busy_o     = (state_q != IDLE);
      drop_o     = drop_q;
   end

endmodule

// File: tb/tb_perf_sample_ctrl.sv
// tb/tb_perf_sample_ctrl.sv - self-checking bench for perf_sample_ctrl
module tb_perf_sample_ctrl;
   import ariane_pkg::*;

   localparam int NC = 6;
   localparam int PW = 16;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            debug_mode;
   logic            csr_req;
   logic [11:0]     csr_addr;
   logic            csr_we;
   logic [XLEN-1:0] csr_wdata;
   logic [XLEN-1:0] csr_rdata;
   logic [11:0]     pc_addr;
   logic            pc_we;
   logic [XLEN-1:0] pc_wdata;
   logic [XLEN-1:0] pc_rdata;
   logic            cfg_en;
   logic [PW-1:0]   cfg_period;
   logic            smp_valid;
   logic            smp_ready;
   logic [2:0]      smp_idx;
   logic [63:0]     smp_data;
   logic            smp_last;
   logic            busy;
   logic            drop;

   always #5 clk = ~clk;

   perf_sample_ctrl #(.NumCounters(NC), .PeriodWidth(PW)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .debug_mode_i (debug_mode),
      .csr_req_i    (csr_req),
      .csr_addr_i   (csr_addr),
      .csr_we_i     (csr_we),
      .csr_wdata_i  (csr_wdata),
      .csr_rdata_o  (csr_rdata),
      .pc_addr_o    (pc_addr),
      .pc_we_o      (pc_we),
      .pc_wdata_o   (pc_wdata),
      .pc_rdata_i   (pc_rdata),
      .cfg_en_i     (cfg_en),
      .cfg_period_i (cfg_period),
      .smp_valid_o  (smp_valid),
      .smp_ready_i  (smp_ready),
      .smp_idx_o    (smp_idx),
      .smp_data_o   (smp_data),
      .smp_last_o   (smp_last),
      .busy_o       (busy),
      .drop_o       (drop)
   );

   // Counter block model: static values, combinational read
   logic [63:0] cnt [NC];

   always_comb begin
      pc_rdata = '0;
      for (int i = 0; i < NC; i++) begin
         if (pc_addr == CSR_MHPM_COUNTER_3 + 12'(i))  pc_rdata = XLEN'(cnt[i]);
         if (pc_addr == CSR_MHPM_COUNTER_3H + 12'(i)) pc_rdata = XLEN'(cnt[i] >> 32);
      end
   end

   typedef struct packed {
      logic [2:0]  idx;
      logic [63:0] data;
      logic        last;
      logic        chk;
   } beat_t;

   typedef struct {
      int          period;
      logic [63:0] base;
      int          lat;
   } vec_t;

   beat_t exp_q[$];
   int    n_cmp  = 0;
   int    n_bad  = 0;
   int    n_drop = 0;
   int    adj;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard consumer: every accepted beat must match the next expected one
   always @(negedge clk) begin
      if (rst_n && smp_valid && smp_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_beat: got idx %0d data %0h expected no beat", smp_idx, smp_data);
         end else begin
            beat_t e;
            e = exp_q.pop_front();
            check("beat_idx", 64'(smp_idx), 64'(e.idx));
            if (e.chk) check("beat_data", smp_data, e.data);
            check("beat_last", 64'(smp_last), 64'(e.last));
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && drop) n_drop++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_counters(input logic [63:0] base);
      for (int i = 0; i < NC; i++) cnt[i] = base + 64'(i);
   endtask

   task automatic push_burst();
`ifdef PERF_SAMPLE_TIMESTAMP_EN
      exp_q.push_back('{idx: 3'd7, data: 64'd0, last: 1'b0, chk: 1'b0});
`endif
      for (int i = 0; i < NC; i++)
         exp_q.push_back('{idx: 3'(i), data: cnt[i], last: (i == NC - 1), chk: 1'b1});
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!smp_valid && lat < 300) begin
         step();
         lat++;
      end
   endtask

   task automatic wait_idle(input string name);
      int t;
      t = 0;
      while (busy && t < 300) begin
         step();
         t++;
      end
      check({name, "_done"}, 64'(t < 300), 64'd1);
      check({name, "_all_beats"}, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic check_outputs_zero(input string name);
      check(name, {59'd0, smp_valid, smp_last, busy, drop, 1'b0}, 64'd0);
      check({name, "_idx"}, 64'(smp_idx), 64'd0);
      check({name, "_data"}, smp_data, 64'd0);
   endtask

   vec_t vt[4];

   initial begin
      int    lat;
      int    t;
      int    busy_seen;
      int    drop_base;
      int    hold_start;
      logic  held;
      logic [67:0] snap;

`ifdef PERF_SAMPLE_TIMESTAMP_EN
      adj = -1;
`else
      adj = (XLEN == 32) ? 1 : 0;
`endif
      // period, counter base, first-valid latency on a 64-bit core without timestamps
      vt[0] = '{10, 64'd100,                  12};
      vt[1] = '{4,  64'h0000_0001_0000_0005,  6};
      vt[2] = '{7,  64'hFFFF_FFFF_FFFF_FFF0,  9};
      vt[3] = '{20, 64'd0,                    22};

      rst_n = 1'b0;
      debug_mode = 1'b0;
      csr_req = 1'b0;
      csr_addr = '0;
      csr_we = 1'b0;
      csr_wdata = '0;
      cfg_en = 1'b0;
      cfg_period = '0;
      smp_ready = 1'b1;
      load_counters(64'd0);
      repeat (3) step();

      check_outputs_zero("reset_outputs");
      check("reset_csr_rdata", 64'(csr_rdata), 64'd0);
      check("reset_pc_we", 64'(pc_we), 64'd0);
      check("reset_pc_addr", 64'(pc_addr), 64'd0);
      rst_n = 1'b1;
      step();

      // Table-driven bursts with free-flowing ready
      for (int v = 0; v < 4; v++) begin
         cfg_en = 1'b0;
         cfg_period = PW'(vt[v].period);
         load_counters(vt[v].base);
         push_burst();
         repeat (3) step();
         cfg_en = 1'b1;
         wait_valid(lat);
         check("first_valid_latency", 64'(lat), 64'(vt[v].lat + adj));
         cfg_en = 1'b0;
         wait_idle("table_burst");
      end

      // CSR priority during RD_LO of counter 2
      cfg_period = PW'(6);
      load_counters(64'd1000);
      push_burst();
      repeat (3) step();
      cfg_en = 1'b1;
      t = 0;
      while (!(pc_addr == CSR_MHPM_COUNTER_3 + 12'd2) && t < 200) begin
         step();
         t++;
      end
      check("csr_reach_k2", 64'(t < 200), 64'd1);
      cfg_en = 1'b0;
      csr_req = 1'b1;
      csr_addr = CSR_MHPM_COUNTER_3 + 12'd5;
      csr_we = 1'b0;
      #1;
      check("csr_read_k5", 64'(csr_rdata), 64'(XLEN'(cnt[5])));
      check("csr_addr_mux", 64'(pc_addr), 64'(CSR_MHPM_COUNTER_3 + 12'd5));
      step();
      csr_addr = CSR_MHPM_COUNTER_3;
      csr_we = 1'b1;
      csr_wdata = XLEN'(777);
      #1;
      check("csr_write_we", 64'(pc_we), 64'd1);
      check("csr_write_data", 64'(pc_wdata), 64'd777);
      step();
      cnt[0] = 64'd777;
      csr_we = 1'b0;
      #1;
      check("csr_readback", 64'(csr_rdata), 64'd777);
      step();
      csr_req = 1'b0;
      #1;
      check("csr_idle_rdata", 64'(csr_rdata), 64'd0);
      check("sampler_resume_addr", 64'(pc_addr), 64'(CSR_MHPM_COUNTER_3 + 12'd2));
      wait_idle("csr_burst");

      // Backpressure on counter 1 for 20 cycles, two ticks land inside the burst
      cfg_period = PW'(8);
      load_counters(64'd2000);
      push_burst();
      repeat (3) step();
      drop_base = n_drop;
      held = 1'b0;
      hold_start = 0;
      snap = '0;
      cfg_en = 1'b1;
      for (int n = 1; n <= 70; n++) begin
         step();
         if (held && n <= hold_start + 20) begin
            check("bp_stable", 64'({smp_valid, smp_idx, smp_data} != snap), 64'd0);
            if (n == hold_start + 20) smp_ready = 1'b1;
         end
         if (!held && smp_valid && smp_idx == 3'd1) begin
            held = 1'b1;
            hold_start = n;
            smp_ready = 1'b0;
            snap = {smp_valid, smp_idx, smp_data};
         end
         if (n == 26) cfg_en = 1'b0;
      end
      check("bp_held", 64'(held), 64'd1);
      check("bp_drop_count", 64'(n_drop - drop_base), 64'd2);
      smp_ready = 1'b1;
      wait_idle("bp_burst");

      // Debug freeze: period 5, timer held at 3 for 50 cycles
      cfg_period = PW'(5);
      load_counters(64'd3000);
      push_burst();
      repeat (3) step();
      cfg_en = 1'b1;
      step();
      step();
      debug_mode = 1'b1;
      busy_seen = 0;
      for (int n = 0; n < 50; n++) begin
         step();
         if (busy || smp_valid) busy_seen++;
      end
      debug_mode = 1'b0;
      check("dbg_no_tick", 64'(busy_seen), 64'd0);
      wait_valid(lat);
      check("dbg_resume_latency", 64'(lat), 64'(5 + adj));
      cfg_en = 1'b0;
      wait_idle("dbg_burst");

      // Reset in the middle of a burst at counter 3
      cfg_period = PW'(6);
      load_counters(64'd4000);
      push_burst();
      repeat (3) step();
      cfg_en = 1'b1;
      t = 0;
      while (!(smp_valid && smp_idx == 3'd3) && t < 200) begin
         step();
         t++;
      end
      check("rst_reach_k3", 64'(t < 200), 64'd1);
      rst_n = 1'b0;
      cfg_en = 1'b0;
      #1;
      check_outputs_zero("rst_mid_outputs");
      exp_q.delete();
      step();
      check_outputs_zero("rst_mid_next");
      check("rst_mid_idle_addr", 64'(pc_addr), 64'd0);
      rst_n = 1'b1;
      load_counters(64'd5000);
      push_burst();
      repeat (3) step();
      cfg_en = 1'b1;
      wait_valid(lat);
      check("post_rst_latency", 64'(lat), 64'(8 + adj));
      cfg_en = 1'b0;
      wait_idle("post_rst_burst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
